// File: rtl/alu_md_pkg.sv
// alu_md_pkg: op codes and FSM state type shared by the ALU and its mul/div unit
package alu_md_pkg;
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;
    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;
endpackage

// File: rtl/alu_md_if.sv
// alu_md_if: operand, result and mul/div handshake bundle between control and ALU
interface alu_md_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] x, y, r, hi, lo;
    logic [3:0] aluc;
    logic [1:0] md_op;
    logic z, v, md_start, md_busy, md_done, hi_we, lo_we;
    modport master(output x, y, aluc, md_op, md_start, hi_we, lo_we,
                   input r, z, v, md_busy, md_done, hi, lo);
    modport slave(input x, y, aluc, md_op, md_start, hi_we, lo_we,
                  output r, z, v, md_busy, md_done, hi, lo);
endinterface

// File: rtl/alu_md_md_unit.sv
// md_unit: iterative shift-add multiplier / restoring divider with HI/LO registers
module md_unit import alu_md_pkg::*; #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    md_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] acc, q, m, ax, ay, acc_n, q_n, hi_fix, lo_fix;
    logic [WIDTH:0] madd;
    logic [2*WIDTH-1:0] prod_s;
    logic dv, neg_p, neg_x, sx, sy, ge;
    assign sx = md_op[0] & x[WIDTH-1];
    assign sy = md_op[0] & y[WIDTH-1];
    assign ax = sx ? -x : x;
    assign ay = sy ? -y : y;
    // acc:q is the product (multiply) or remainder:quotient shift pair (divide)
    assign madd = {1'b0, acc} + {1'b0, q[0] ? m : '0};
    assign ge = {acc, q[WIDTH-1]} >= {1'b0, m};
    assign acc_n = dv ? (ge ? {acc[WIDTH-2:0], q[WIDTH-1]} - m : {acc[WIDTH-2:0], q[WIDTH-1]}) : madd[WIDTH:1];
    assign q_n = dv ? {q[WIDTH-2:0], ge} : {madd[0], q[WIDTH-1:1]};
    assign prod_s = neg_p ? -{acc, q} : {acc, q};
    assign hi_fix = dv ? (neg_x ? -acc : acc) : prod_s[2*WIDTH-1:WIDTH];
    assign lo_fix = dv ? (m == '0 ? '1 : neg_p ? -q : q) : prod_s[WIDTH-1:0];
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) state <= IDLE;
        else state <= state_n;
    always_comb
        state_n = state == IDLE ? (md_start ? CALC : IDLE)
                : state == CALC ? (cnt == CW'(WIDTH-1) ? FIX : CALC)
                : IDLE;
    always_comb md_busy = state != IDLE;
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            cnt <= '0;
            acc <= '0;
            q <= '0;
            m <= '0;
            dv <= 1'b0;
            neg_p <= 1'b0;
            neg_x <= 1'b0;
            hi <= '0;
            lo <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= state == FIX;
            if (state == IDLE && md_start) begin
                dv <= md_op[1];
                neg_p <= sx ^ sy;
                neg_x <= sx;
                cnt <= '0;
                acc <= '0;
                m <= md_op[1] ? ay : ax;
                q <= md_op[1] ? ax : ay;
            end else if (state == IDLE) begin
                if (hi_we) hi <= x;
                if (lo_we) lo <= x;
            end else if (state == CALC) begin
                acc <= acc_n;
                q <= q_n;
                cnt <= cnt + CW'(1);
            end else begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
endmodule

// File: rtl/alu_md.sv
// alu_md: single-cycle ALU result path plus iterative mul/div unit with HI/LO
module alu_md import alu_md_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input logic clk,
    input logic clrn,
    alu_md_if.slave bus
);
    logic [WIDTH-1:0] add, sub, shr;
    logic [SHW-1:0] sh;
    assign sh = bus.x[SHW-1:0];
    assign add = bus.x + bus.y;
    assign sub = bus.x - bus.y;
    assign shr = bus.aluc[3] ? WIDTH'($signed(bus.y) >>> sh) : bus.y >> sh;
    assign bus.r = bus.aluc[1:0] == 2'b00 ? (bus.aluc[2] ? sub : add)
                 : bus.aluc[1:0] == 2'b01 ? (bus.aluc[2] ? bus.x | bus.y : bus.x & bus.y)
                 : bus.aluc[1:0] == 2'b10 ? (bus.aluc[2] ? {bus.y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : bus.x ^ bus.y)
                 : (bus.aluc[2] ? shr : bus.y << sh);
    assign bus.z = ~|bus.r;
    // overflow: operands agree in sign (add) or differ (sub) and the result sign flips
    assign bus.v = bus.aluc[1:0] == 2'b00 &&
                   (bus.aluc[2] ? (bus.x[WIDTH-1] != bus.y[WIDTH-1] && sub[WIDTH-1] != bus.x[WIDTH-1])
                                : (bus.x[WIDTH-1] == bus.y[WIDTH-1] && add[WIDTH-1] != bus.x[WIDTH-1]));
    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk(clk),
        .clrn(clrn),
        .x(bus.x),
        .y(bus.y),
        .md_start(bus.md_start),
        .md_op(bus.md_op),
        .hi_we(bus.hi_we),
        .lo_we(bus.lo_we),
        .md_busy(bus.md_busy),
        .md_done(bus.md_done),
        .hi(bus.hi),
        .lo(bus.lo)
    );
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle CPU's combinational ALU.
- Keeps the single-cycle result path (r/z), generalised to WIDTH bits, and adds arithmetic-shift-right and a signed-overflow flag.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake, used by the control unit to stall on mult/multu/div/divu.

Parameters:
- WIDTH, 32, datapath width; even, at least 8.
- SHW, $clog2(WIDTH), shift-amount width taken from x[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- x  in  WIDTH  operand A (rs); also the shift amount source and mthi/mtlo data.
- y  in  WIDTH  operand B (rt/imm).
- aluc  in  4  single-cycle op select.
- r  out  WIDTH  combinational result.
- z  out  1  r == 0.
- v  out  1  signed overflow for add/sub; 0 for all other ops.
- md_start  in  1  start a mul/div on x, y.
- md_op  in  2  00 multu, 01 mult, 10 divu, 11 div.
- hi_we  in  1  write x into HI (mthi).
- lo_we  in  1  write x into LO (mtlo).
- md_busy  out  1  unit is iterating.
- md_done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
Single-cycle path (purely combinational, no clock involvement):
- aluc[1:0]=00: aluc[2]=0 gives x+y, aluc[2]=1 gives x-y; v = signed overflow of that operation.
- aluc[1:0]=01: aluc[2]=0 gives x&y, aluc[2]=1 gives x|y.
- aluc[1:0]=10: aluc[2]=0 gives x^y, aluc[2]=1 gives lui = {y[WIDTH/2-1:0], WIDTH/2 zeros}.
- aluc[1:0]=11 (shift y by x[SHW-1:0]):
  - aluc[2]=0: sll.
  - aluc[2]=1, aluc[3]=0: srl.
  - aluc[2]=1, aluc[3]=1: sra.
- z = ~|r.
Mul/div FSM, states IDLE, CALC, FIX:
- Reset (clrn=0, async): state IDLE; counter=0; hi=0; lo=0; md_busy=0; md_done=0; internal operand registers=0.
- IDLE, md_start=1 at an edge:
  - latch x, y, md_op.
  - for signed ops, convert operands to magnitudes (unsigned WIDTH bits, so MIN is handled) and record the result signs.
  - go to CALC; md_busy=1 from the next cycle.
- CALC: exactly WIDTH cycles.
  - Multiply: shift-add over a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle.
  - Go to FIX when the counter reaches WIDTH-1.
- FIX: one cycle, apply sign correction.
  - mult: negate the 2W product if signs differ.
  - div: quotient negative if signs differ; remainder takes the dividend's sign.
  - At the edge ending FIX: write HI/LO, md_done=1 for exactly one cycle, md_busy=0, state IDLE.
- Latency: the start edge is edge 0; md_done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles.
- Result mapping: mult gives {hi,lo} = product; div gives lo = quotient, hi = remainder.
- Divide by zero: runs the full latency; lo = all ones; hi = dividend (original signed value for div).
- div MIN/-1: lo = MIN, hi = 0, no trap.
- md_start while busy: ignored; no queueing.
- hi_we/lo_we: take effect only in IDLE and only when md_start=0.
  - Ignored while busy.
  - Simultaneous start and write: start wins, write dropped.
  - hi_we and lo_we together: both written with x.
- md_done coincident with md_start: the unit is IDLE in that cycle, so a new start is accepted.
- clrn low mid-operation: immediate abort, all state returns to reset values, no md_done pulse.

Decomposition:
- Package alu_md_pkg holds:
  - ALUC_* op codes: ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA.
  - MD_MULTU, MD_MULT, MD_DIVU, MD_DIV.
  - md_state_t enum: IDLE, CALC, FIX.
- One sub-module, md_unit: holds the FSM, counter, iterative datapath and HI/LO.
- The top level contains the combinational ALU mux and instantiates md_unit.

Test Plan (WIDTH=32):
- Single-cycle ops:
  - aluc=SUB, x=5, y=5 -> r=0, z=1, v=0.
  - aluc=ADD, x=7FFFFFFF, y=1 -> r=80000000, v=1.
  - aluc=SRA, x=4, y=80000000 -> r=F8000000, z=0.
  - aluc=LUI, y=0000ABCD -> r=ABCD0000.
- mult x=FFFFFFFD (-3), y=5 -> md_busy high 33 cycles, md_done 34 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFF1.
- div x=7, y=FFFFFFFE (-2) -> lo=FFFFFFFD, hi=00000001.
- div MIN/-1: x=80000000, y=FFFFFFFF -> lo=80000000, hi=0.
- divu x=00001234, y=0 -> lo=FFFFFFFF, hi=00001234 after full latency.
- Handshake: md_start pulsed at cycle 10 of a multu -> ignored, original result delivered. hi_we while busy -> HI unchanged. hi_we=1, x=CAFEF00D in IDLE -> hi=CAFEF00D next cycle.
- Reset mid-operation: clrn low at cycle 12 of a mult -> md_busy=0, hi=lo=0 immediately, no md_done. A new start after release completes normally.
